pipeline_hazard_ctrl: RTL and testbench

- Hazard and stall controller for the 5-stage MIPS pipeline.
- Drives the enable and flush controls of the PC, IF_ID and ID_EX pipeline registers.
- Handles three cases: load-use stalls, branch/jump redirect flushes, and multi-cycle data-memory waits, with a timeout fault.
- Keeps saturating performance counters for stall and flush cycles.

---
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: load-use bubbles,
// redirect flushes, data-memory wait holds with timeout fault, and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MEMRead_ID_EX,
  input  logic [4:0]       Rt_ID_EX,
  input  logic [4:0]       Rs_IF_ID,
  input  logic [4:0]       Rt_IF_ID,
  input  logic             branch_taken,
  input  logic             jump_EX,
  input  logic             mem_busy,
  output logic             Enable_PC,
  output logic             Enable_IF_ID,
  output logic             Enable_ID_EX,
  output logic             Flush_IF_ID,
  output logic             Flush_ID_EX,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT,
    FAULT
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              stall_inc, flush_inc, fault_set;
  logic              load_use, redirect;
  logic              en_pc, en_ifid, en_idex, fl_ifid, fl_idex;

  assign load_use = MEMRead_ID_EX && (Rt_ID_EX != 5'd0) &&
                    ((Rt_ID_EX == Rs_IF_ID) || (Rt_ID_EX == Rt_IF_ID));
  assign redirect = branch_taken || jump_EX;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      fault        <= 1'b0;
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (fault_set)
        fault <= 1'b1;
      if (stall_inc && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
      if (flush_inc && (flush_cycles != {CNT_W{1'b1}}))
        flush_cycles <= flush_cycles + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    fault_set  = 1'b0;
    en_pc      = 1'b1;
    en_ifid    = 1'b1;
    en_idex    = 1'b1;
    fl_ifid    = 1'b0;
    fl_idex    = 1'b0;

    case (state)
      RUN, LOAD_STALL: begin
        if (mem_busy) begin
          en_pc      = 1'b0;
          en_ifid    = 1'b0;
          en_idex    = 1'b0;
          state_next = MEM_WAIT;
          wait_next  = WAIT_W'(1);
          stall_inc  = 1'b1;
        end else if (state == LOAD_STALL) begin
          // The bubble is already in EX; release without re-checking load_use.
          state_next = RUN;
        end else if (redirect) begin
          fl_ifid   = 1'b1;
          fl_idex   = 1'b1;
          flush_inc = 1'b1;
        end else if (load_use) begin
          en_pc      = 1'b0;
          en_ifid    = 1'b0;
          fl_idex    = 1'b1;
          state_next = LOAD_STALL;
          stall_inc  = 1'b1;
        end
      end

      MEM_WAIT: begin
        en_pc     = 1'b0;
        en_ifid   = 1'b0;
        en_idex   = 1'b0;
        stall_inc = 1'b1;
        if (!mem_busy) begin
          state_next = RUN;
          wait_next  = '0;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
          state_next = FAULT;
          fault_set  = 1'b1;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end

      default: begin
        en_pc   = 1'b0;
        en_ifid = 1'b0;
        en_idex = 1'b0;
      end
    endcase
  end

  // Reset forces the pipeline registers into a held, bubbled condition.
  always_comb begin
    Enable_PC    = en_pc   && !reset;
    Enable_IF_ID = en_ifid && !reset;
    Enable_ID_EX = en_idex && !reset;
    Flush_IF_ID  = fl_ifid || reset;
    Flush_ID_EX  = fl_idex || reset;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; expected control vectors
// flow through a scoreboard queue, counters and fault are compared after each edge.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, MEMRead_ID_EX, branch_taken, jump_EX, mem_busy;
  logic [4:0] Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;

  logic        Enable_PC, Enable_IF_ID, Enable_ID_EX, Flush_IF_ID, Flush_ID_EX, fault;
  logic [15:0] stall_cycles, flush_cycles;

  logic       s_en_pc, s_en_ifid, s_en_idex, s_fl_ifid, s_fl_idex, s_fault;
  logic [3:0] s_stall, s_flush;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .MEMRead_ID_EX(MEMRead_ID_EX), .Rt_ID_EX(Rt_ID_EX),
    .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID), .branch_taken(branch_taken),
    .jump_EX(jump_EX), .mem_busy(mem_busy), .Enable_PC(Enable_PC),
    .Enable_IF_ID(Enable_IF_ID), .Enable_ID_EX(Enable_ID_EX),
    .Flush_IF_ID(Flush_IF_ID), .Flush_ID_EX(Flush_ID_EX), .fault(fault),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  // Narrow-counter instance shares all inputs and is used for saturation checks.
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .MEMRead_ID_EX(MEMRead_ID_EX), .Rt_ID_EX(Rt_ID_EX),
    .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID), .branch_taken(branch_taken),
    .jump_EX(jump_EX), .mem_busy(mem_busy), .Enable_PC(s_en_pc),
    .Enable_IF_ID(s_en_ifid), .Enable_ID_EX(s_en_idex),
    .Flush_IF_ID(s_fl_ifid), .Flush_ID_EX(s_fl_idex), .fault(s_fault),
    .stall_cycles(s_stall), .flush_cycles(s_flush)
  );

  // {Enable_PC, Enable_IF_ID, Enable_ID_EX, Flush_IF_ID, Flush_ID_EX}
  localparam logic [4:0] C_NORM  = 5'b11100;
  localparam logic [4:0] C_HOLD  = 5'b00000;
  localparam logic [4:0] C_RST   = 5'b00011;
  localparam logic [4:0] C_REDIR = 5'b11111;
  localparam logic [4:0] C_LU    = 5'b00101;

  logic [4:0] ctrl;
  assign ctrl = {Enable_PC, Enable_IF_ID, Enable_ID_EX, Flush_IF_ID, Flush_ID_EX};

  typedef struct {
    string      tag;
    logic [4:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    exp_t e;
    e = sb.pop_front();
    check(e.tag, {27'd0, ctrl}, {27'd0, e.ctrl});
  endtask

  task automatic apply_stimulus(input string tag, input logic rst, input logic mr,
                                input logic [4:0] rtex, input logic [4:0] rs,
                                input logic [4:0] rt, input logic br, input logic jp,
                                input logic busy, input logic [4:0] exp_ctrl);
    @(negedge clk);
    reset         = rst;
    MEMRead_ID_EX = mr;
    Rt_ID_EX      = rtex;
    Rs_IF_ID      = rs;
    Rt_IF_ID      = rt;
    branch_taken  = br;
    jump_EX       = jp;
    mem_busy      = busy;
    sb.push_back('{tag, exp_ctrl});
    #1;
    check_output();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [4:0] exp_ctrl);
    apply_stimulus(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ctrl);
  endtask

  task automatic do_reset(input string tag);
    apply_stimulus(tag, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_RST);
  endtask

  initial begin
    reset = 1'b1; MEMRead_ID_EX = 1'b0; branch_taken = 1'b0; jump_EX = 1'b0;
    mem_busy = 1'b0; Rt_ID_EX = 5'd0; Rs_IF_ID = 5'd0; Rt_IF_ID = 5'd0;

    do_reset("reset_ctrl0");
    do_reset("reset_ctrl1");
    check("reset_fault", {31'd0, fault}, 32'd0);
    check("reset_stall", {16'd0, stall_cycles}, 32'd0);
    check("reset_flush", {16'd0, flush_cycles}, 32'd0);
    idle("idle_run", C_NORM);

    // Load-use through rs, inputs held a second cycle: still only one bubble.
    apply_stimulus("lu_rs", 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, C_LU);
    check("lu_rs_stall", {16'd0, stall_cycles}, 32'd1);
    apply_stimulus("lu_release", 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, C_NORM);
    check("lu_release_stall", {16'd0, stall_cycles}, 32'd1);
    apply_stimulus("lu_rt", 0, 1, 5'd9, 5'd1, 5'd9, 0, 0, 0, C_LU);
    idle("lu_rt_release", C_NORM);
    check("lu_rt_stall", {16'd0, stall_cycles}, 32'd2);
    apply_stimulus("lu_r0", 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NORM);
    apply_stimulus("lu_nomatch", 0, 1, 5'd8, 5'd3, 5'd4, 0, 0, 0, C_NORM);
    check("lu_r0_stall", {16'd0, stall_cycles}, 32'd2);

    // Redirect wins over a concurrent load-use.
    apply_stimulus("redir_lu", 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, 0, C_REDIR);
    check("redir_flush", {16'd0, flush_cycles}, 32'd1);
    check("redir_stall", {16'd0, stall_cycles}, 32'd2);
    apply_stimulus("jump", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_REDIR);
    check("jump_flush", {16'd0, flush_cycles}, 32'd2);
    idle("after_jump", C_NORM);

    // Memory wait of 4 busy cycles; redirect/load-use during the wait are ignored.
    do_reset("reset_before_wait");
    apply_stimulus("busy1", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, C_HOLD);
    for (int i = 2; i <= 4; i++)
      apply_stimulus("busy_n", 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, 1, C_HOLD);
    idle("busy_drop_hold", C_HOLD);
    check("wait_stall", {16'd0, stall_cycles}, 32'd5);
    check("wait_fault", {31'd0, fault}, 32'd0);
    check("wait_flush", {16'd0, flush_cycles}, 32'd0);
    idle("wait_resume", C_NORM);

    // Reset in the middle of a memory wait.
    apply_stimulus("midwait_busy1", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, C_HOLD);
    apply_stimulus("midwait_busy2", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, C_HOLD);
    apply_stimulus("midwait_reset", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, C_RST);
    check("midwait_stall", {16'd0, stall_cycles}, 32'd0);
    idle("midwait_resume", C_NORM);

    // Timeout: fault after 16 busy cycles, counters frozen afterwards.
    for (int i = 1; i <= 20; i++) begin
      apply_stimulus("timeout_busy", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, C_HOLD);
      if (i == 15) check("timeout_fault_15", {31'd0, fault}, 32'd0);
      if (i == 16) begin
        check("timeout_fault_16", {31'd0, fault}, 32'd1);
        check("timeout_stall_16", {16'd0, stall_cycles}, 32'd16);
        check("timeout_stall_sat4", {28'd0, s_stall}, 32'd15);
      end
    end
    check("fault_stall_frozen", {16'd0, stall_cycles}, 32'd16);
    apply_stimulus("fault_hold", 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, C_HOLD);
    check("fault_sticky", {31'd0, fault}, 32'd1);
    check("fault_flush_frozen", {16'd0, flush_cycles}, 32'd0);
    do_reset("fault_reset");
    check("fault_cleared", {31'd0, fault}, 32'd0);
    check("fault_reset_stall", {16'd0, stall_cycles}, 32'd0);
    idle("fault_resume", C_NORM);

    // Flush counter saturation on the 4-bit instance.
    for (int i = 1; i <= 20; i++) begin
      apply_stimulus("sat_redir", 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, C_REDIR);
      if (i == 14) check("sat_flush4_14", {28'd0, s_flush}, 32'd14);
    end
    check("sat_flush4_20", {28'd0, s_flush}, 32'd15);
    check("sat_flush16_20", {16'd0, flush_cycles}, 32'd20);

    // Reset while in LOAD_STALL.
    idle("ls_pre", C_NORM);
    apply_stimulus("ls_enter", 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, C_LU);
    apply_stimulus("ls_reset", 1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, C_RST);
    check("ls_reset_stall", {16'd0, stall_cycles}, 32'd0);
    check("ls_reset_flush", {16'd0, flush_cycles}, 32'd0);
    idle("ls_resume", C_NORM);
    apply_stimulus("ls_lu_again", 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, C_LU);
    check("ls_lu_again_stall", {16'd0, stall_cycles}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
